awgn_ctrl: RTL and testbench
============================

AWGN_CTRL -- requirements
Module: awgn_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output buffer depth (power of two, >=2).
REQ-002 Parameter CNT_W, default 24, sample-count width.
REQ-003 Parameter RST_CYC, default 2, core reset hold cycles.
REQ-004 clk  in  1  clock, all logic posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 seed_we  in  1  write seed_data into seed slot seed_idx.
REQ-007 seed_idx  in  3  seed slot 0..5; values 6,7 ignored.
REQ-008 seed_data  in  32  seed value.
REQ-009 num_samples  in  CNT_W  samples to deliver per run, sampled at start.
REQ-010 warmup  in  8  discarded core cycles after core reset release, sampled at start.
REQ-011 start  in  1  single-cycle run request.
REQ-012 core_rst  out  1  reset to AWGN core, active-high.
REQ-013 core_seed  out  192  six seeds, slot k at bits [32k+31:32k].
REQ-014 core_out  in  16  AWGN core sample, new value every clk.
REQ-015 m_data  out  16  output sample.
REQ-016 m_valid  out  1  m_data valid.
REQ-017 m_ready  in  1  downstream accepts.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 done  out  1  one-cycle pulse at run completion.
REQ-020 drop_cnt  out  16  saturating count of samples lost to a full FIFO, cleared at start.

Function
REQ-021 FSM states: IDLE, CRST, WARM, RUN, DRAIN, DONE.
REQ-022 IDLE: start=1 with num_samples!=0 -> CRST; start=1 with num_samples=0 -> DONE; otherwise stay.
REQ-023 CRST: core_rst=1 for exactly RST_CYC cycles -> WARM; core_rst=0 in every other state except during rst.
REQ-024 WARM: discard core_out for warmup cycles, then -> RUN; warmup=0 goes to RUN on the first cycle after CRST.
REQ-025 RUN: push core_out into the FIFO each cycle; increment the pushed count on each successful push; pushed count reaching num_samples -> DRAIN.
REQ-026 RUN with FIFO full and no pop in the same cycle: sample discarded, not counted, drop_cnt+1, saturating at 16'hFFFF.
REQ-027 FIFO full with a pop in the same cycle: the push succeeds.
REQ-028 DRAIN: no pushes; FIFO empty -> DONE.
REQ-029 DONE: done=1 for one cycle -> IDLE.
REQ-030 Stream rule: a transfer occurs when m_valid & m_ready; m_valid = FIFO not empty; m_data held stable while m_valid & !m_ready.
REQ-031 Latency: the first sample pushed appears on m_data in the cycle after its push; samples are delivered in push order.
REQ-032 Delivered sample count equals num_samples exactly.
REQ-033 seed_we is honoured only in IDLE; writes while busy are ignored.
REQ-034 core_seed is driven directly from the seed registers and is stable for the whole run.
REQ-035 start is ignored while busy.

Reset
REQ-036 rst asserted: state IDLE, core_rst=1, m_valid=0, done=0, busy=0, drop_cnt=0, FIFO empty, counters 0.
REQ-037 rst asserted: all six seeds = 32'h8000_0000.
REQ-038 rst asserted mid-run: the run is aborted with no done pulse; on release, state IDLE and core_rst=0.

Structure
REQ-039 Package awgn_pkg holds the FSM state enum, NUM_SEEDS=6, SEED_DEFAULT=32'h8000_0000 and SAMPLE_W=16.
REQ-040 The FIFO is one sub-module, awgn_fifo: synchronous, single clock, with full/empty flags and simultaneous push/pop.

Verification
REQ-041 Reset, then start with num_samples=16, warmup=4, m_ready=1 -> core_rst high 2 cycles; 16 transfers matching core_out taken 7 cycles after start onward; done pulses once; drop_cnt=0.
REQ-042 Seed writes idx0..5 = 1..6, then idx 7 = 9 -> core_seed = {6,5,4,3,2,1}; idx 7 write has no effect.
REQ-043 num_samples=100, m_ready=0 for 20 cycles then 1 -> m_data stable while stalled; drop_cnt = number of RUN cycles with the FIFO full; exactly 100 delivered.
REQ-044 start with num_samples=0 -> done the next cycle; core_rst never asserted; no m_valid.
REQ-045 rst asserted in RUN after 5 of 50 samples -> m_valid=0, no done pulse; the next start completes normally.
REQ-046 start and seed_we pulsed while busy -> both ignored; the run completes with the original seeds and count.

Source files
------------

// File: rtl/awgn_pkg.sv
// ---------------------------------------------------------------------------
// awgn_pkg
// Shared definitions for the AWGN core controller: controller FSM states,
// number of core seeds, seed reset value and sample width.
// ---------------------------------------------------------------------------
package awgn_pkg;

    localparam int          NUM_SEEDS    = 6;
    localparam logic [31:0] SEED_DEFAULT = 32'h8000_0000;
    localparam int          SAMPLE_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_WARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/awgn_fifo.sv
// ---------------------------------------------------------------------------
// awgn_fifo
// Single-clock synchronous FIFO with a show-ahead read port. A write becomes
// visible on dout in the cycle after the push. Simultaneous push and pop is
// allowed, including when the FIFO is full.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (FIFO becomes empty)
//   push, din  write request and data (ignored when full without a pop)
//   pop        read request (ignored when empty)
//   dout       head-of-queue data, valid while !empty
//   full       DEPTH entries stored
//   empty      no entries stored
// ---------------------------------------------------------------------------
module awgn_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the empty flag masks stale
    // contents, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/awgn_ctrl.sv
// ---------------------------------------------------------------------------
// awgn_ctrl
// Run controller for an external AWGN noise core. On start it pulses the
// core reset, discards a programmable number of warm-up samples, then
// streams exactly num_samples core samples through an output FIFO with a
// valid/ready handshake. Samples arriving while the FIFO is full (and not
// being popped) are dropped and counted.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   seed_we/idx/data      seed slot write (slots 0..5, honoured only in IDLE)
//   num_samples, warmup   run length and warm-up cycles, sampled at start
//   start                 single-cycle run request (ignored while busy)
//   core_rst, core_seed   reset and seed bus to the AWGN core
//   core_out              AWGN core sample, new value every cycle
//   m_data/m_valid/m_ready output sample stream
//   busy, done            run in progress / one-cycle completion pulse
//   drop_cnt              saturating count of samples lost to a full FIFO
// ---------------------------------------------------------------------------
module awgn_ctrl
    import awgn_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 24,
    parameter int RST_CYC    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_we,
    input  logic [2:0]             seed_idx,
    input  logic [31:0]            seed_data,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic [7:0]             warmup,
    input  logic                   start,
    output logic                   core_rst,
    output logic [32*NUM_SEEDS-1:0] core_seed,
    input  logic [SAMPLE_W-1:0]    core_out,
    output logic [SAMPLE_W-1:0]    m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            drop_cnt
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t           state;
    logic [RC_W-1:0]  rst_cnt;
    logic [7:0]       warm_cnt;
    logic [7:0]       warm_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] pushed_cnt;
    logic [31:0]      seed_q [NUM_SEEDS];

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_ok;

    assign pop     = m_valid && m_ready;
    assign push_ok = (state == S_RUN) && (!fifo_full || pop);

    assign m_valid = !fifo_empty;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    // rst is folded in so the core is held in reset for as long as we are,
    // and released as soon as rst drops (state is IDLE then).
    assign core_rst = rst || (state == S_CRST);

    awgn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (core_out),
        .pop   (pop),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            warm_cnt   <= '0;
            warm_q     <= '0;
            num_q      <= '0;
            pushed_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q      <= num_samples;
                        warm_q     <= warmup;
                        pushed_cnt <= '0;
                        drop_cnt   <= '0;
                        rst_cnt    <= '0;
                        state      <= (num_samples == '0) ? S_DONE : S_CRST;
                    end
                end
                S_CRST: begin
                    if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                        // Zero warm-up skips WARM entirely.
                        if (warm_q == 8'd0) begin
                            state <= S_RUN;
                        end else begin
                            warm_cnt <= warm_q;
                            state    <= S_WARM;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_WARM: begin
                    if (warm_cnt == 8'd1) state <= S_RUN;
                    else                  warm_cnt <= warm_cnt - 8'd1;
                end
                S_RUN: begin
                    if (push_ok) begin
                        pushed_cnt <= pushed_cnt + CNT_W'(1);
                        if (pushed_cnt == num_q - CNT_W'(1)) state <= S_DRAIN;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Seeds only change in IDLE so the core sees a constant seed bus per run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SEEDS; k++) seed_q[k] <= SEED_DEFAULT;
        end else if (seed_we && (state == S_IDLE) && (seed_idx < 3'(NUM_SEEDS))) begin
            seed_q[seed_idx] <= seed_data;
        end
    end

    // NOTE: every bit of core_seed is assigned on each evaluation, so this
    // combinational block cannot infer a latch.
    always_comb begin
        for (int k = 0; k < NUM_SEEDS; k++) core_seed[32*k +: 32] = seed_q[k];
    end

endmodule

// File: tb/tb_awgn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_awgn_ctrl
// Self-checking bench for awgn_ctrl. A reference model (a queue standing for
// the FIFO plus phase arithmetic derived from start time, reset length and
// warm-up) predicts m_valid/m_data, core_rst, busy, done and drop_cnt every
// cycle under random core samples and random or scripted back-pressure.
// ---------------------------------------------------------------------------
module tb_awgn_ctrl;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 24;
    localparam int RST_CYC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             seed_we;
    logic [2:0]       seed_idx;
    logic [31:0]      seed_data;
    logic [CNT_W-1:0] num_samples;
    logic [7:0]       warmup;
    logic             start;
    logic             core_rst;
    logic [191:0]     core_seed;
    logic [15:0]      core_out;
    logic [15:0]      m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [15:0]      drop_cnt;

    logic [191:0] exp_seed;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    awgn_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W),
        .RST_CYC    (RST_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_we     (seed_we),
        .seed_idx    (seed_idx),
        .seed_data   (seed_data),
        .num_samples (num_samples),
        .warmup      (warmup),
        .start       (start),
        .core_rst    (core_rst),
        .core_seed   (core_seed),
        .core_out    (core_out),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .done        (done),
        .drop_cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] default_seeds();
        logic [191:0] s;
        for (int k = 0; k < 6; k++) s[32*k +: 32] = 32'h8000_0000;
        return s;
    endfunction

    task automatic write_seed(input logic [2:0] idx, input logic [31:0] val);
        seed_we = 1'b1; seed_idx = idx; seed_data = val;
        tick();
        seed_we = 1'b0;
        if (idx < 3'd6) exp_seed[32*idx +: 32] = val;
    endtask

    // mode 0: always ready; 1: not ready for the first 'stall' cycles; 2: random
    function automatic logic ready_for(input int mode, input int stall, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n >= stall);
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One complete run. abort_at>0 asserts rst once that many samples were
    // delivered; inject pulses start and seed_we while busy.
    task automatic run_case(input string tag, input int num, input int w, input int mode,
                            input int stall, input int abort_at, input bit inject);
        logic [15:0] q[$];
        int   pushed = 0;
        int   drops  = 0;
        int   delivered = 0;
        int   limit  = num * 6 + stall + w + 100;
        bit   done_fired = 0;
        bit   finished = 0;
        bit   was_done, in_run, pop, push, exp_done;
        int   qsize_pre, pushed_pre;
        logic [15:0] cur;

        start = 1'b1; num_samples = CNT_W'(num); warmup = 8'(w);
        m_ready = ready_for(mode, stall, 0);
        core_out = 16'($urandom);
        for (int n = 0; n < limit; n++) begin
            qsize_pre  = q.size();
            pushed_pre = pushed;
            pop    = (qsize_pre > 0) && m_ready;
            in_run = (n - 1 >= RST_CYC + w) && (pushed < num);
            push   = in_run && (qsize_pre < DEPTH || pop);
            cur    = core_out;
            was_done = done_fired;
            exp_done = !done_fired && (pushed_pre == num) && (qsize_pre == 0);
            tick();
            if (pop) begin void'(q.pop_front()); delivered++; end
            if (push) begin q.push_back(cur); pushed++; end
            if (in_run && !push && drops < 65535) drops++;
            if (exp_done) done_fired = 1;

            check({tag, ".m_valid"}, m_valid, q.size() != 0);
            if (q.size() != 0) check({tag, ".m_data"}, m_data, q[0]);
            check({tag, ".done"}, done, exp_done);
            check({tag, ".busy"}, busy, !was_done);
            check({tag, ".core_rst"}, core_rst, (num != 0) && (n < RST_CYC));
            check({tag, ".core_seed"}, core_seed, exp_seed);
            if (was_done) begin finished = 1; break; end

            if (abort_at > 0 && delivered == abort_at) begin
                rst = 1'b1;
                #1;
                exp_seed = default_seeds();
                check({tag, ".abort_m_valid"}, m_valid, 1'b0);
                check({tag, ".abort_core_rst"}, core_rst, 1'b1);
                check({tag, ".abort_busy"}, busy, 1'b0);
                check({tag, ".abort_seed"}, core_seed, exp_seed);
                start = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check({tag, ".abort_done"}, done, 1'b0);
                end
                rst = 1'b0;
                #1;
                check({tag, ".release_core_rst"}, core_rst, 1'b0);
                check({tag, ".release_busy"}, busy, 1'b0);
                check({tag, ".release_drop"}, drop_cnt, 16'd0);
                tick();
                check({tag, ".release_idle_done"}, done, 1'b0);
                return;
            end

            if (inject && n == 1) begin
                start = 1'b1; num_samples = CNT_W'(num + 5);
                seed_we = 1'b1; seed_idx = 3'd0; seed_data = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; seed_we = 1'b0;
            end
            m_ready  = ready_for(mode, stall, n + 1);
            core_out = 16'($urandom);
        end
        start = 1'b0; seed_we = 1'b0;
        check({tag, ".terminated"}, finished, 1'b1);
        check({tag, ".delivered"}, delivered, num);
        check({tag, ".drop_cnt"}, drop_cnt, drops);
        check({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; seed_we = 1'b0; seed_idx = '0; seed_data = '0;
        num_samples = '0; warmup = '0; start = 1'b0; core_out = '0; m_ready = 1'b1;
        exp_seed = default_seeds();
        #1;
        check("rst.core_rst", core_rst, 1'b1);
        check("rst.m_valid", m_valid, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.drop_cnt", drop_cnt, 16'd0);
        check("rst.seeds", core_seed, exp_seed);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rel.core_rst", core_rst, 1'b0);
        tick();

        for (int k = 0; k < 6; k++) write_seed(3'(k), 32'(k + 1));
        write_seed(3'd7, 32'd9);
        tick();
        check("seed.bus", core_seed,
              {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});

        run_case("basic", 16, 4, 0, 0, 0, 1'b0);
        tick();
        run_case("stall", 100, 3, 1, 20, 0, 1'b0);
        tick();
        run_case("zero", 0, 5, 0, 0, 0, 1'b0);
        tick();
        run_case("abort", 50, 4, 0, 0, 5, 1'b0);
        run_case("after_abort", 20, 0, 2, 0, 0, 1'b0);
        tick();
        write_seed(3'd2, 32'h1234_5678);
        write_seed(3'd5, 32'hCAFE_F00D);
        run_case("busy_ignore", 30, 2, 2, 0, 0, 1'b1);
        tick();
        for (int r = 0; r < 4; r++) begin
            run_case("random", $urandom_range(1, 40), $urandom_range(0, 10), 2, 0, 0, 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
